// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: the ID/EX hazard inputs, memory and debug
// requests, and the per-stage stall/flush controls with their status outputs.
interface hazard_ctrl_if;
    logic [4:0]  id_r1_i;
    logic [4:0]  id_r2_i;
    logic        id_r1_used_i;
    logic        id_r2_used_i;
    logic [4:0]  idex_rd_i;
    logic        idex_mem_re_i;
    logic        br_jmp_en_i;
    logic        dmem_busy_i;
    logic        dbg_halt_i;
    logic        dbg_resume_i;
    logic [4:0]  stall_o;
    logic [4:0]  flush_o;
    logic        halted_o;
    logic        mem_timeout_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;

    modport master (
        output id_r1_i, id_r2_i, id_r1_used_i, id_r2_used_i,
        output idex_rd_i, idex_mem_re_i, br_jmp_en_i, dmem_busy_i,
        output dbg_halt_i, dbg_resume_i,
        input  stall_o, flush_o, halted_o, mem_timeout_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_r1_i, id_r2_i, id_r1_used_i, id_r2_used_i,
        input  idex_rd_i, idex_mem_re_i, br_jmp_en_i, dmem_busy_i,
        input  dbg_halt_i, dbg_resume_i,
        output stall_o, flush_o, halted_o, mem_timeout_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, data-memory wait with
// timeout, and debug halt/resume. Define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module hazard_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_HALT
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    localparam logic [4:0] STALL_LOAD_USE = 5'b00011;
    localparam logic [4:0] FLUSH_LOAD_USE = 5'b00100;
    localparam logic [4:0] FLUSH_BRANCH   = 5'b00110;
    localparam logic [4:0] STALL_MEM      = 5'b01111;
    localparam logic [4:0] FLUSH_MEM      = 5'b10000;

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout_q, timeout_d;
    logic       halt_armed_q, halt_armed_d;
    logic       halt_pend_q, halt_pend_d;
    logic       lu_done_q, lu_done_d;

    logic       lu_raw;
    logic       halt_new;
    logic       run_rules;
    logic       lu_stall;
    logic [4:0] stall_core;
    logic [4:0] flush_core;

    always_comb begin
        lu_raw = hz.idex_mem_re_i && (hz.idex_rd_i != '0) &&
                 (((hz.idex_rd_i == hz.id_r1_i) && hz.id_r1_used_i) ||
                  ((hz.idex_rd_i == hz.id_r2_i) && hz.id_r2_used_i));
        halt_new = hz.dbg_halt_i && halt_armed_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_RUN;
            wait_q       <= '0;
            timeout_q    <= 1'b0;
            halt_armed_q <= 1'b1;
            halt_pend_q  <= 1'b0;
            lu_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            timeout_q    <= timeout_d;
            halt_armed_q <= halt_armed_d;
            halt_pend_q  <= halt_pend_d;
            lu_done_q    <= lu_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        timeout_d   = timeout_q;
        halt_pend_d = halt_pend_q;
        run_rules   = 1'b0;
        lu_stall    = 1'b0;
        stall_core  = '0;
        flush_core  = '0;

        unique case (state_q)
            ST_RUN: begin
                if (hz.dmem_busy_i) begin
                    stall_core  = STALL_MEM;
                    flush_core  = FLUSH_MEM;
                    wait_d      = 8'd1;
                    halt_pend_d = halt_new;
                    state_d     = ST_MEM_WAIT;
                end else begin
                    run_rules = 1'b1;
                    state_d   = halt_new ? ST_HALT : ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_busy_i && (wait_q < WAIT_LIMIT)) begin
                    stall_core  = STALL_MEM;
                    flush_core  = FLUSH_MEM;
                    wait_d      = wait_q + 8'd1;
                    halt_pend_d = halt_pend_q || halt_new;
                end else begin
                    // Wait over (memory ready or timed out): a halt requested during it takes effect now.
                    run_rules   = 1'b1;
                    timeout_d   = timeout_q || hz.dmem_busy_i;
                    wait_d      = '0;
                    halt_pend_d = 1'b0;
                    state_d     = (halt_pend_q || halt_new) ? ST_HALT : ST_RUN;
                end
            end
            ST_HALT: begin
                stall_core = '1;
                if (hz.dbg_resume_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (run_rules) begin
            if (hz.br_jmp_en_i) begin
                flush_core = FLUSH_BRANCH;
            end else if (lu_raw && !lu_done_q) begin
                stall_core = STALL_LOAD_USE;
                flush_core = FLUSH_LOAD_USE;
                lu_stall   = 1'b1;
            end
        end

        // A held hazard stalls once; it must clear before another stall can issue.
        lu_done_d = lu_raw && (lu_done_q || lu_stall);

        if ((state_q == ST_HALT) && hz.dbg_resume_i) begin
            halt_armed_d = !hz.dbg_halt_i;
        end else begin
            halt_armed_d = halt_armed_q || !hz.dbg_halt_i;
        end
    end

    assign hz.stall_o       = rst ? 5'b00000 : stall_core;
    assign hz.flush_o       = rst ? 5'b11111 : flush_core;
    assign hz.halted_o      = (state_q == ST_HALT);
    assign hz.mem_timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Branch flush is the only source of the 00110 pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_core[0]) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_core == FLUSH_BRANCH) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
`else
    assign hz.stall_cnt_o = '0;
    assign hz.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (wait limits 16 and 4) share the
// same directed and random stimulus; a reference model predicts each cycle's outputs.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic       busy;
        logic       halt;
        logic       resume;
        logic       rst;
    } stim_t;

    typedef struct packed {
        logic [4:0]  stall;
        logic [4:0]  flush;
        logic        halted;
        logic        timeout;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } obs_t;

    localparam int MAX_A = 16;
    localparam int MAX_B = 4;
    localparam int M_RUN  = 0;
    localparam int M_WAIT = 1;
    localparam int M_HALT = 2;

    logic  clk = 1'b0;
    logic  rst;
    stim_t s;

    always #5 clk = ~clk;

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();

    assign rst = s.rst;

    always_comb begin
        ifa.id_r1_i = s.r1;       ifb.id_r1_i = s.r1;
        ifa.id_r2_i = s.r2;       ifb.id_r2_i = s.r2;
        ifa.id_r1_used_i = s.u1;  ifb.id_r1_used_i = s.u1;
        ifa.id_r2_used_i = s.u2;  ifb.id_r2_used_i = s.u2;
        ifa.idex_rd_i = s.rd;     ifb.idex_rd_i = s.rd;
        ifa.idex_mem_re_i = s.ld; ifb.idex_mem_re_i = s.ld;
        ifa.br_jmp_en_i = s.br;   ifb.br_jmp_en_i = s.br;
        ifa.dmem_busy_i = s.busy; ifb.dmem_busy_i = s.busy;
        ifa.dbg_halt_i = s.halt;  ifb.dbg_halt_i = s.halt;
        ifa.dbg_resume_i = s.resume; ifb.dbg_resume_i = s.resume;
    end

    hazard_ctrl #(.MEM_WAIT_MAX(MAX_A)) dut_a (.clk(clk), .rst(rst), .hz(ifa));
    hazard_ctrl #(.MEM_WAIT_MAX(MAX_B)) dut_b (.clk(clk), .rst(rst), .hz(ifb));

    // Reference model state, one slot per instance.
    int          m_mode [2];
    int          m_wait [2];
    bit          m_pend [2];
    bit          m_block[2];
    bit          m_lu   [2];
    bit          m_to   [2];
    int unsigned m_sc   [2];
    int unsigned m_fc   [2];

    obs_t qa[$];
    obs_t qb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    task automatic model(input int d, input stim_t v, output obs_t e);
        int   lim;
        logic dep, ask, was_halt, holding;
        lim = (d == 0) ? MAX_A : MAX_B;
        e = '0;
        if (v.rst) begin
            m_mode[d] = M_RUN; m_wait[d] = 0; m_pend[d] = 0; m_block[d] = 0;
            m_lu[d] = 0; m_to[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
            e.flush = 5'b11111;
            return;
        end
        dep = v.ld && (v.rd != 5'd0) && (((v.rd == v.r1) && v.u1) || ((v.rd == v.r2) && v.u2));
        ask = v.halt && !m_block[d];
        was_halt = (m_mode[d] == M_HALT);
        e.halted  = was_halt;
        e.timeout = m_to[d];
`ifdef HAZARD_PERF_CNT_EN
        e.scnt = m_sc[d];
        e.fcnt = m_fc[d];
`endif
        if (was_halt) begin
            e.stall = 5'b11111;
            if (v.resume) m_mode[d] = M_RUN;
        end else begin
            holding = v.busy && ((m_mode[d] == M_RUN) || (m_wait[d] < lim));
            if (holding) begin
                e.stall = 5'b01111;
                e.flush = 5'b10000;
                m_wait[d] = (m_mode[d] == M_RUN) ? 1 : m_wait[d] + 1;
                m_pend[d] = m_pend[d] || ask;
                m_mode[d] = M_WAIT;
            end else begin
                if (v.busy) m_to[d] = 1;
                if (v.br) begin
                    e.flush = 5'b00110;
                end else if (dep && !m_lu[d]) begin
                    e.stall = 5'b00011;
                    e.flush = 5'b00100;
                end
                m_mode[d] = (ask || m_pend[d]) ? M_HALT : M_RUN;
                m_pend[d] = 0;
                m_wait[d] = 0;
            end
        end
        m_lu[d] = dep && (m_lu[d] || (e.stall == 5'b00011));
        if (was_halt && v.resume) m_block[d] = v.halt;
        else if (!v.halt)         m_block[d] = 0;
        if (e.stall[0])           m_sc[d] = m_sc[d] + 1;
        if (e.flush == 5'b00110)  m_fc[d] = m_fc[d] + 1;
    endtask

    task automatic tick(input stim_t v);
        obs_t ea, eb;
        @(posedge clk);
        #1;
        s = v;
        model(0, v, ea);
        model(1, v, eb);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic check(input int d, input bit have, input obs_t a, input obs_t e);
        n_checks++;
        if (!have) begin
            $display("FAIL dut%0d cyc%0d no_expected got stall=%b flush=%b", d, cyc, a.stall, a.flush);
        end else if (a === e) begin
            n_pass++;
        end else begin
            $display("FAIL dut%0d cyc%0d outputs got stall=%b flush=%b halted=%b to=%b sc=%0d fc=%0d exp stall=%b flush=%b halted=%b to=%b sc=%0d fc=%0d",
                     d, cyc, a.stall, a.flush, a.halted, a.timeout, a.scnt, a.fcnt,
                     e.stall, e.flush, e.halted, e.timeout, e.scnt, e.fcnt);
        end
    endtask

    always @(negedge clk) begin
        obs_t a, e;
        bit   have;
        cyc++;
        have = (qa.size() > 0);
        e = have ? qa.pop_front() : '0;
        a = {ifa.stall_o, ifa.flush_o, ifa.halted_o, ifa.mem_timeout_o, ifa.stall_cnt_o, ifa.flush_cnt_o};
        check(0, have, a, e);
        have = (qb.size() > 0);
        e = have ? qb.pop_front() : '0;
        a = {ifb.stall_o, ifb.flush_o, ifb.halted_o, ifb.mem_timeout_o, ifb.stall_cnt_o, ifb.flush_cnt_o};
        check(1, have, a, e);
    end

    initial begin
        stim_t v;
        int    busy_left;
        logic  halt_lvl;
        s = '0;
        s.rst = 1'b1;

        v = '0; v.rst = 1'b1; repeat (3) tick(v);
        v = '0; repeat (2) tick(v);

        // Load-use on rs2, then the same with rd = x0.
        v.ld = 1'b1; v.rd = 5'd5; v.r2 = 5'd5; v.u2 = 1'b1; repeat (3) tick(v);
        v.rd = 5'd0; repeat (3) tick(v);

        // Branch together with a load-use hazard.
        v = '0; v.ld = 1'b1; v.rd = 5'd7; v.r1 = 5'd7; v.u1 = 1'b1; v.br = 1'b1; tick(v);
        v.br = 1'b0; repeat (2) tick(v);
        v = '0; tick(v);

        // Short memory wait, then a held busy that times out the limit-4 instance.
        v.busy = 1'b1; repeat (3) tick(v);
        v.busy = 1'b0; repeat (2) tick(v);
        v.busy = 1'b1; repeat (10) tick(v);
        v.busy = 1'b0; repeat (2) tick(v);

        // Halt for five cycles, resume while halt still high, then drop halt.
        v.halt = 1'b1; repeat (5) tick(v);
        v.resume = 1'b1; tick(v);
        v.resume = 1'b0; repeat (3) tick(v);
        v.halt = 1'b0; repeat (2) tick(v);

        // Halt during a memory wait takes effect once the wait ends.
        v = '0; v.busy = 1'b1; tick(v);
        v.halt = 1'b1; tick(v);
        v.halt = 1'b0; tick(v);
        v.busy = 1'b0; tick(v);
        repeat (3) tick(v);
        v.resume = 1'b1; tick(v);
        v.resume = 1'b0; tick(v);

        // Reset in the middle of a wait with a pending halt, and in the middle of HALT.
        v = '0; v.busy = 1'b1; repeat (2) tick(v);
        v.halt = 1'b1; tick(v);
        v = '0; v.rst = 1'b1; tick(v);
        v = '0; repeat (3) tick(v);
        v.halt = 1'b1; repeat (2) tick(v);
        v = '0; v.rst = 1'b1; tick(v);
        v = '0; repeat (2) tick(v);

        busy_left = 0;
        halt_lvl  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            v = '0;
            v.r1 = 5'($urandom_range(0, 3));
            v.r2 = 5'($urandom_range(0, 3));
            v.rd = 5'($urandom_range(0, 3));
            v.u1 = 1'($urandom_range(0, 1));
            v.u2 = 1'($urandom_range(0, 1));
            v.ld = 1'($urandom_range(0, 1));
            v.br = ($urandom_range(0, 4) == 0);
            if ((busy_left == 0) && ($urandom_range(0, 11) == 0)) busy_left = int'($urandom_range(1, 20));
            v.busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            if ($urandom_range(0, 24) == 0) halt_lvl = !halt_lvl;
            v.halt   = halt_lvl;
            v.resume = ($urandom_range(0, 9) == 0);
            v.rst    = ($urandom_range(0, 299) == 0);
            tick(v);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 16, maximum consecutive data-memory wait cycles before timeout (range 1..255).
REQ-002 SHALL have clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have the following ports, one per entry as name  direction  width  meaning:
- id_r1_i  in  5  rs1 address of the instruction in ID.
- id_r2_i  in  5  rs2 address of the instruction in ID.
- id_r1_used_i  in  1  ID instruction reads rs1.
- id_r2_used_i  in  1  ID instruction reads rs2.
- idex_rd_i  in  5  rd address of the instruction in EX.
- idex_mem_re_i  in  1  the instruction in EX is a load.
- br_jmp_en_i  in  1  branch or jump taken, resolved in EX.
- dmem_busy_i  in  1  data memory not ready this cycle.
- dbg_halt_i  in  1  halt request, level.
- dbg_resume_i  in  1  resume request, single-cycle pulse.
- stall_o  out  5  per-stage hold: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb.
- flush_o  out  5  per-stage bubble insert, same bit mapping as stall_o.
- halted_o  out  1  high in HALT.
- mem_timeout_o  out  1  sticky memory-timeout flag.
- stall_cnt_o  out  32  stall-cycle counter.
- flush_cnt_o  out  32  branch-flush counter.

Function
REQ-005 SHALL implement an FSM with states RUN, MEM_WAIT and HALT; stall_o and flush_o SHALL be Mealy outputs, combinational from the state and inputs.
REQ-006 In RUN, a load-use hazard SHALL exist when all of the following hold: idex_mem_re_i=1; idex_rd_i!=0; idex_rd_i equals id_r1_i with id_r1_used_i=1, or equals id_r2_i with id_r2_used_i=1.
REQ-007 In RUN with br_jmp_en_i=1, outputs SHALL be stall_o=00000 and flush_o=00110; this takes priority over a load-use hazard.
REQ-008 In RUN with a load-use hazard and no branch, outputs SHALL be stall_o=00011 and flush_o=00100, for exactly one cycle per hazard.
REQ-009 In RUN with dmem_busy_i=1, the block SHALL output stall_o=01111 and flush_o=10000 in that same cycle and enter MEM_WAIT next cycle with the wait counter set to 1; dmem_busy_i overrides branch and load-use.
REQ-010 In MEM_WAIT, outputs SHALL be stall_o=01111 and flush_o=10000 while dmem_busy_i=1, and br_jmp_en_i SHALL be ignored.
REQ-011 In MEM_WAIT with dmem_busy_i=0, the block SHALL apply the RUN output rules (REQ-007/008) in that cycle and return to RUN.
REQ-012 The wait counter SHALL increment each busy cycle in MEM_WAIT; on reaching MEM_WAIT_MAX, the block SHALL set mem_timeout_o=1 (sticky until reset), release the stall that cycle, and return to RUN.
REQ-013 With dbg_halt_i=1 in RUN and no memory busy, the block SHALL enter HALT next cycle; in MEM_WAIT the halt SHALL be deferred until the wait ends.
REQ-014 In HALT, outputs SHALL be stall_o=11111, flush_o=00000 and halted_o=1; dbg_resume_i=1 SHALL return to RUN next cycle regardless of dbg_halt_i level, and dbg_halt_i must drop before it re-arms.
REQ-015 Simultaneous dbg_halt_i and br_jmp_en_i in RUN SHALL apply the flush that cycle and then enter HALT.

Reset
REQ-016 While rst=1, the state SHALL be RUN, the wait counter 0, stall_o=00000, flush_o=11111, halted_o=0, mem_timeout_o=0, and both counters 0.
REQ-017 Reset asserted mid-MEM_WAIT or mid-HALT SHALL abort immediately, with no pending halt or timeout retained.

Configuration
REQ-018 With HAZARD_PERF_CNT_EN defined, stall_cnt_o SHALL increment on every cycle with stall_o[0]=1, and flush_cnt_o SHALL increment on every cycle with REQ-007 active; both SHALL wrap modulo 2^32.
REQ-019 Without HAZARD_PERF_CNT_EN, stall_cnt_o and flush_cnt_o SHALL be constant 0 and no counter flops SHALL be synthesised.

Verification
REQ-020 Load-use test: idex_mem_re_i=1, idex_rd_i=5, id_r2_i=5, id_r2_used_i=1 -> one cycle of stall_o=00011, flush_o=00100, then 00000/00000.
REQ-021 x0 load test: same as REQ-020 but idex_rd_i=0 -> no stall and no flush.
REQ-022 Branch/load-use priority test: br_jmp_en_i=1 together with a load-use hazard -> flush_o=00110, stall_o=00000.
REQ-023 Memory wait test: dmem_busy_i high for 3 cycles with MEM_WAIT_MAX=16 -> 3 cycles of stall_o=01111, flush_o=10000, then RUN, mem_timeout_o=0.
REQ-024 Timeout test: dmem_busy_i held high with MEM_WAIT_MAX=4 -> stall released after 4 cycles, mem_timeout_o=1 and remains 1.
REQ-025 Halt/resume test: dbg_halt_i=1 in RUN, then dbg_resume_i pulse 5 cycles later -> halted_o=1 and stall_o=11111 for 5 cycles, RUN next cycle; with HAZARD_PERF_CNT_EN, stall_cnt_o=5.
